// File: rtl/fir_seq_pkg.sv
// Shared types and width helpers for the FIR tap/sample sequencer.
package fir_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        RUN    = 2'd2,
        DRAIN  = 2'd3
    } seq_state_t;

    // Width needed to index n items, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int tap_width(input int filter_length);
        return idx_width(filter_length);
    endfunction

    function automatic int ch_width(input int num_ch);
        return idx_width(num_ch);
    endfunction

endpackage

// File: rtl/fir_seq_dly.sv
// Fixed-latency valid+data delay line; every stage shifts each clock.
module fir_seq_dly #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    // Stage 0 sits in the LSBs; the oldest entry is at the top.
    logic [DEPTH-1:0]       vld_sr;
    logic [DEPTH*WIDTH-1:0] dat_sr;

    // Shift one stage per cycle; reset flushes anything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_sr <= '0;
            dat_sr <= '0;
        end else begin
            vld_sr <= DEPTH'({vld_sr, in_valid});
            dat_sr <= (DEPTH*WIDTH)'({dat_sr, in_data});
        end
    end

    assign out_valid = vld_sr[DEPTH-1];
    assign out_data  = dat_sr[DEPTH*WIDTH-1 -: WIDTH];

endmodule

// File: rtl/fir_seq_timer.sv
// Tap/sample sequencer for the DSP58 FIR cascade: warm-up, per-channel tap
// walk, accumulator strobes and a latency-matched result-valid.
// Optional macro FIR_SEQ_HOLD_EN adds a 'hold' input that freezes the walk.
module fir_seq_timer
    import fir_seq_pkg::*;
#(
    parameter int  FILTER_LENGTH  = 16,
    parameter int  DSP_LATENCY    = 4,
    parameter int  NUM_CH         = 1,
    parameter int  STARTUP_CYCLES = 7,
    localparam int TAP_W          = tap_width(FILTER_LENGTH),
    localparam int CH_W           = ch_width(NUM_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
`ifdef FIR_SEQ_HOLD_EN
    input  logic            hold,
`endif
    output logic [TAP_W-1:0] tap_idx,
    output logic [CH_W-1:0]  ch_idx,
    output logic             sample_strobe,
    output logic             acc_clr,
    output logic             last_tap,
    output logic             out_valid,
    output logic [CH_W-1:0]  out_ch,
    output logic             busy,
    output logic             done
);

    localparam int WARM_W = idx_width(STARTUP_CYCLES);
    localparam int DRN_W  = idx_width(DSP_LATENCY);

    logic hold_eff;
`ifdef FIR_SEQ_HOLD_EN
    assign hold_eff = hold;
`else
    assign hold_eff = 1'b0;
`endif

    seq_state_t        state, state_nxt;
    logic [WARM_W-1:0] warm_cnt, warm_cnt_nxt;
    logic [DRN_W-1:0]  drn_cnt, drn_cnt_nxt;
    // 'arm' marks the single RUN cycle before the first tap of a run is issued.
    logic              arm, arm_nxt;
    logic              stop_pend, stop_pend_nxt;
    logic [TAP_W-1:0]  tap_nxt;
    logic [CH_W-1:0]   ch_nxt;
    logic              strobe_nxt, last_nxt, busy_nxt, done_nxt;
    logic              frame_end;
    logic [CH_W-1:0]   dly_in;

    assign frame_end = (tap_idx == TAP_W'(FILTER_LENGTH - 1));

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        state_nxt     = state;
        warm_cnt_nxt  = warm_cnt;
        drn_cnt_nxt   = drn_cnt;
        arm_nxt       = arm;
        stop_pend_nxt = stop_pend;
        tap_nxt       = tap_idx;
        ch_nxt        = ch_idx;
        strobe_nxt    = 1'b0;
        last_nxt      = 1'b0;
        done_nxt      = 1'b0;

        case (state)
            IDLE: begin
                stop_pend_nxt = 1'b0;
                if (start) begin
                    warm_cnt_nxt = '0;
                    if (STARTUP_CYCLES == 0) begin
                        state_nxt = RUN;
                        arm_nxt   = 1'b1;
                    end else begin
                        state_nxt = WARMUP;
                    end
                end
            end

            WARMUP: begin
                if (stop) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (!hold_eff) begin
                    if (warm_cnt == WARM_W'(STARTUP_CYCLES - 1)) begin
                        state_nxt = RUN;
                        arm_nxt   = 1'b1;
                    end else begin
                        warm_cnt_nxt = warm_cnt + WARM_W'(1);
                    end
                end
            end

            RUN: begin
                stop_pend_nxt = stop_pend | stop;
                if (!hold_eff) begin
                    if (arm || frame_end) begin
                        // Frame boundary: either open the next frame or drain.
                        if (stop || stop_pend) begin
                            state_nxt   = DRAIN;
                            drn_cnt_nxt = '0;
                            arm_nxt     = 1'b0;
                            tap_nxt     = '0;
                        end else begin
                            arm_nxt    = 1'b0;
                            tap_nxt    = '0;
                            strobe_nxt = 1'b1;
                            if (arm) begin
                                ch_nxt = '0;
                            end else if (ch_idx == CH_W'(NUM_CH - 1)) begin
                                ch_nxt = '0;
                            end else begin
                                ch_nxt = ch_idx + CH_W'(1);
                            end
                        end
                    end else begin
                        tap_nxt  = tap_idx + TAP_W'(1);
                        last_nxt = (tap_idx == TAP_W'(FILTER_LENGTH - 2));
                    end
                end
            end

            DRAIN: begin
                if (drn_cnt == DRN_W'(DSP_LATENCY - 1)) begin
                    state_nxt     = IDLE;
                    done_nxt      = 1'b1;
                    stop_pend_nxt = 1'b0;
                end else begin
                    drn_cnt_nxt = drn_cnt + DRN_W'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and registered outputs; reset returns everything to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            warm_cnt      <= '0;
            drn_cnt       <= '0;
            arm           <= 1'b0;
            stop_pend     <= 1'b0;
            tap_idx       <= '0;
            ch_idx        <= '0;
            sample_strobe <= 1'b0;
            acc_clr       <= 1'b0;
            last_tap      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            state         <= state_nxt;
            warm_cnt      <= warm_cnt_nxt;
            drn_cnt       <= drn_cnt_nxt;
            arm           <= arm_nxt;
            stop_pend     <= stop_pend_nxt;
            tap_idx       <= tap_nxt;
            ch_idx        <= ch_nxt;
            sample_strobe <= strobe_nxt;
            acc_clr       <= strobe_nxt;
            last_tap      <= last_nxt;
            busy          <= busy_nxt;
            done          <= done_nxt;
        end
    end

    // Only the channel of a finished frame enters the result delay line.
    assign dly_in = last_tap ? ch_idx : '0;

    fir_seq_dly #(
        .DEPTH (DSP_LATENCY),
        .WIDTH (CH_W)
    ) u_dly (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (last_tap),
        .in_data   (dly_in),
        .out_valid (out_valid),
        .out_data  (out_ch)
    );

endmodule

// File: tb/tb_fir_seq_timer.sv
// Directed bench for fir_seq_timer: default build, 3-channel build and a
// zero-warm-up build; hold scenario compiled in with FIR_SEQ_HOLD_EN.
module tb_fir_seq_timer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Instance A: defaults (L=16, D=4, 1 channel, 7 warm-up cycles)
    logic       a_start = 1'b0, a_stop = 1'b0, a_hold = 1'b0;
    logic [3:0] a_tap;
    logic [0:0] a_ch, a_och;
    logic       a_ss, a_clr, a_last, a_ov, a_busy, a_done;

    // Instance B: L=4, 3 channels
    logic       b_start = 1'b0, b_stop = 1'b0, b_hold = 1'b0;
    logic [1:0] b_tap;
    logic [1:0] b_ch, b_och;
    logic       b_ss, b_clr, b_last, b_ov, b_busy, b_done;

    // Instance C: no warm-up
    logic       c_start = 1'b0, c_stop = 1'b0, c_hold = 1'b0;
    logic [3:0] c_tap;
    logic [0:0] c_ch, c_och;
    logic       c_ss, c_clr, c_last, c_ov, c_busy, c_done;

    fir_seq_timer u_a (
        .clk(clk), .rst(rst), .start(a_start), .stop(a_stop),
`ifdef FIR_SEQ_HOLD_EN
        .hold(a_hold),
`endif
        .tap_idx(a_tap), .ch_idx(a_ch), .sample_strobe(a_ss), .acc_clr(a_clr),
        .last_tap(a_last), .out_valid(a_ov), .out_ch(a_och), .busy(a_busy), .done(a_done)
    );

    fir_seq_timer #(.FILTER_LENGTH(4), .DSP_LATENCY(4), .NUM_CH(3), .STARTUP_CYCLES(7)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .stop(b_stop),
`ifdef FIR_SEQ_HOLD_EN
        .hold(b_hold),
`endif
        .tap_idx(b_tap), .ch_idx(b_ch), .sample_strobe(b_ss), .acc_clr(b_clr),
        .last_tap(b_last), .out_valid(b_ov), .out_ch(b_och), .busy(b_busy), .done(b_done)
    );

    fir_seq_timer #(.STARTUP_CYCLES(0)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .stop(c_stop),
`ifdef FIR_SEQ_HOLD_EN
        .hold(c_hold),
`endif
        .tap_idx(c_tap), .ch_idx(c_ch), .sample_strobe(c_ss), .acc_clr(c_clr),
        .last_tap(c_last), .out_valid(c_ov), .out_ch(c_och), .busy(c_busy), .done(c_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset state ----------------
        step(3);
        rst = 1'b0;
        step(1);
        chk("rst_tap", a_tap, 0);
        chk("rst_ch", a_ch, 0);
        chk("rst_strobes", {a_ss, a_clr, a_last}, 0);
        chk("rst_out", {a_ov, a_och}, 0);
        chk("rst_busy_done", {a_busy, a_done}, 0);

        // ---------------- defaults: main sequence, start while busy, stop ----------------
        a_start = 1'b1; step(1); a_start = 1'b0;          // cycle k
        chk("a_busy_k", a_busy, 1);
        chk("a_ss_k", a_ss, 0);
        step(7);                                          // k+7
        chk("a_ss_k7", a_ss, 0);
        step(1);                                          // k+8
        chk("a_ss_k8", a_ss, 1);
        chk("a_clr_k8", a_clr, 1);
        chk("a_tap_k8", a_tap, 0);
        chk("a_last_k8", a_last, 0);
        step(15);                                         // k+23
        chk("a_tap_k23", a_tap, 15);
        chk("a_last_k23", a_last, 1);
        chk("a_ss_k23", a_ss, 0);
        step(1);                                          // k+24
        chk("a_ss_k24", a_ss, 1);
        chk("a_tap_k24", a_tap, 0);
        a_start = 1'b1; step(1); a_start = 1'b0;          // k+25
        chk("a_busy_start", a_tap, 1);
        chk("a_busy_start_b", a_busy, 1);
        step(1);                                          // k+26
        chk("a_ov_k26", a_ov, 0);
        chk("a_tap_k26", a_tap, 2);
        step(1);                                          // k+27
        chk("a_ov_k27", a_ov, 1);
        chk("a_och_k27", a_och, 0);
        step(1);                                          // k+28
        chk("a_ov_k28", a_ov, 0);
        step(1);                                          // k+29
        chk("a_tap_k29", a_tap, 5);
        a_stop = 1'b1; step(1); a_stop = 1'b0;            // k+30
        chk("a_tap_k30", a_tap, 6);
        step(9);                                          // k+39
        chk("a_stop_tap15", a_tap, 15);
        chk("a_stop_last", a_last, 1);
        step(1);                                          // k+40
        chk("a_stop_noss", a_ss, 0);
        chk("a_stop_busy", a_busy, 1);
        step(2);                                          // k+42
        chk("a_stop_ov42", a_ov, 0);
        step(1);                                          // k+43
        chk("a_stop_ov43", a_ov, 1);
        chk("a_stop_done43", a_done, 0);
        chk("a_stop_busy43", a_busy, 1);
        a_start = 1'b1; step(1); a_start = 1'b0;          // k+44
        chk("a_done44", a_done, 1);
        chk("a_busy44", a_busy, 0);
        chk("a_ov44", a_ov, 0);
        step(1);                                          // k+45
        chk("a_done45", a_done, 0);
        chk("a_no_restart", a_busy, 0);

        // ---------------- stop during warm-up ----------------
        a_start = 1'b1; step(1); a_start = 1'b0;          // k
        step(2);
        a_stop = 1'b1; step(1); a_stop = 1'b0;            // k+3
        chk("a_wu_done", a_done, 1);
        chk("a_wu_busy", a_busy, 0);
        for (int i = 0; i < 12; i++) begin
            step(1);
            chk("a_wu_quiet", {a_ss, a_ov, a_busy, a_done}, 0);
        end

        // ---------------- reset mid-operation ----------------
        a_start = 1'b1; step(1); a_start = 1'b0;          // k
        step(23);                                         // k+23
        chk("a_rm_last", a_last, 1);
        step(2);                                          // k+25
        rst = 1'b1; step(1); rst = 1'b0;                  // k+26
        chk("a_rm_tap", a_tap, 0);
        chk("a_rm_ctrl", {a_ch, a_ss, a_clr, a_last, a_busy, a_done}, 0);
        chk("a_rm_out", {a_ov, a_och}, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("a_rm_no_ov", {a_ov, a_busy}, 0);
        end

        // ---------------- 3 channels, 4 taps ----------------
        b_start = 1'b1; step(1); b_start = 1'b0;          // k
        step(8);                                          // k+8, i=0
        for (int i = 0; i < 16; i++) begin
            if (i > 0) step(1);
            chk("b_tap", b_tap, i % 4);
            chk("b_ch", b_ch, (i / 4) % 3);
            chk("b_ov", b_ov, (i == 7 || i == 11 || i == 15) ? 1 : 0);
            if (i == 7 || i == 11 || i == 15) chk("b_och", b_och, (i - 7) / 4);
        end
        b_stop = 1'b1; step(1); b_stop = 1'b0;            // k+24 (stop on last_tap)
        chk("b_stop_noss", b_ss, 0);
        chk("b_stop_busy", b_busy, 1);
        step(3);                                          // k+27
        chk("b_stop_ov", b_ov, 1);
        chk("b_stop_och", b_och, 0);
        step(1);                                          // k+28
        chk("b_done", b_done, 1);
        chk("b_busy_done", b_busy, 0);

        // ---------------- zero warm-up ----------------
        c_start = 1'b1; step(1); c_start = 1'b0;          // k
        chk("c_busy_k", c_busy, 1);
        chk("c_ss_k", c_ss, 0);
        step(1);                                          // k+1
        chk("c_ss_k1", c_ss, 1);
        chk("c_tap_k1", c_tap, 0);
        c_stop = 1'b1; step(1); c_stop = 1'b0;            // k+2
        chk("c_tap_k2", c_tap, 1);
        step(14);                                         // k+16
        chk("c_last", c_last, 1);
        step(4);                                          // k+20
        chk("c_ov", c_ov, 1);
        step(1);                                          // k+21
        chk("c_done", c_done, 1);
        chk("c_busy", c_busy, 0);

`ifdef FIR_SEQ_HOLD_EN
        // ---------------- hold ----------------
        a_start = 1'b1; step(1); a_start = 1'b0;          // k
        step(15);                                         // k+15
        chk("h_tap7", a_tap, 7);
        a_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);                                      // k+16..k+18
            chk("h_tap_frozen", a_tap, 7);
        end
        a_hold = 1'b0;
        step(1);                                          // k+19
        chk("h_tap8", a_tap, 8);
        step(3);                                          // k+22
        chk("h_no_early_last", a_last, 0);
        step(4);                                          // k+26
        chk("h_last_delayed", a_last, 1);
        step(1);                                          // k+27
        chk("h_ss", a_ss, 1);
        step(1);                                          // k+28
        chk("h_tap1", a_tap, 1);
        a_hold = 1'b1;
        step(1);                                          // k+29
        chk("h_ov29", a_ov, 0);
        chk("h_ss_held", a_ss, 0);
        step(1);                                          // k+30
        chk("h_ov_on_time", a_ov, 1);
        chk("h_tap_held", a_tap, 1);
        step(1);                                          // k+31
        a_hold = 1'b0;
        step(1);                                          // k+32
        chk("h_tap2", a_tap, 2);
        a_stop = 1'b1; step(1); a_stop = 1'b0;
        for (int i = 0; i < 40 && !a_done; i++) step(1);
        chk("h_done", a_done, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_seq_timer.md
Name: fir_seq_timer

Overview:
- Parametrised tap/sample sequencer for the DSP58 FIR datapath. It replaces the fixed single-channel delay strobe generator.
- After a programmable warm-up, it walks tap indices across a frame of FILTER_LENGTH cycles, rotating over NUM_CH channels.
- It issues sample-load and accumulator-clear strobes, and a result-valid strobe delayed by the DSP pipeline latency.
- Sits between the sample source / coefficient ROM and the DSP58 cascade. Controlled by start/stop.

Parameters:
- FILTER_LENGTH, 16: taps per frame (cycles per channel result); must be >= 2.
- DSP_LATENCY, 4: cycles from last-tap issue to result valid at the DSP58 output; must be >= 1.
- NUM_CH, 1: number of interleaved channels; must be >= 1.
- STARTUP_CYCLES, 7: warm-up cycles between start and the first tap; 0 allowed.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin sequencing; sampled only in IDLE.
- stop  in  1  request graceful stop; sampled in WARMUP/RUN.
- tap_idx  out  TAP_W  current tap index, where TAP_W = max(1, clog2(FILTER_LENGTH)).
- ch_idx  out  CH_W  channel of the current frame, where CH_W = max(1, clog2(NUM_CH)).
- sample_strobe  out  1  load new input sample (tap_idx==0).
- acc_clr  out  1  clear the DSP accumulator (same cycle as sample_strobe).
- last_tap  out  1  tap_idx==FILTER_LENGTH-1.
- out_valid  out  1  DSP result valid.
- out_ch  out  CH_W  channel of the result on out_valid.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse on return to IDLE after a stop.

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active-high. All outputs are registered.
- Reset:
  - State goes to IDLE.
  - tap_idx=0, ch_idx=0, out_ch=0.
  - All strobes, busy and done are 0.
  - The latency delay line and the stop-pending flag are cleared.
  - rst asserted mid-operation aborts on the next edge; no out_valid is emitted for in-flight frames.
- FSM: IDLE -> WARMUP -> RUN -> DRAIN -> IDLE.
- IDLE:
  - start=1 -> WARMUP, warm counter = 0.
  - If STARTUP_CYCLES==0, go directly to RUN.
  - stop is ignored in IDLE.
- WARMUP:
  - Counts STARTUP_CYCLES cycles, then -> RUN.
  - stop in WARMUP -> IDLE directly with a done pulse; no frames are issued.
- RUN:
  - tap_idx increments each cycle and wraps FILTER_LENGTH-1 -> 0.
  - On wrap, ch_idx increments and wraps NUM_CH-1 -> 0.
  - sample_strobe, acc_clr and last_tap are aligned with tap_idx in the same cycle.
  - Latency: start sampled at edge k gives the first sample_strobe=1 with tap_idx=0, ch_idx=0 after edge k+STARTUP_CYCLES+1.
- stop in RUN:
  - Sets stop-pending. The current frame completes through last_tap of the current channel; it is not truncated.
  - The next edge enters DRAIN instead of starting a new frame.
  - stop on the same cycle as last_tap terminates after that frame.
- DRAIN:
  - Waits DSP_LATENCY cycles so the final out_valid emerges.
  - Then -> IDLE with done=1 for one cycle.
  - busy=0 in that same cycle.
- out_valid / out_ch:
  - A last_tap in cycle t produces out_valid=1 in cycle t+DSP_LATENCY.
  - out_ch carries the ch_idx of that frame.
  - Implemented as a DSP_LATENCY-deep shift register of {valid, ch}. It shifts every cycle in all states except after reset.
- start while busy is ignored. A start in the same cycle as done's IDLE entry is not sampled; it is only accepted from the next cycle.

Optional Feature:
- Macro: FIR_SEQ_HOLD_EN.
- Defined:
  - Adds an input port hold (1 bit).
  - hold=1 in RUN freezes tap_idx and ch_idx, and forces sample_strobe, acc_clr and last_tap to 0.
  - The latency delay line keeps shifting, so pending results still appear on schedule.
  - hold in WARMUP freezes the warm counter. hold is ignored in IDLE and DRAIN.
  - stop is still latched while held.
- Not defined: the port is absent and behaviour equals hold=0.

Decomposition:
- Package fir_seq_pkg holds:
  - the FSM state enum {IDLE, WARMUP, RUN, DRAIN};
  - width helper functions for TAP_W and CH_W.
- One sub-module, fir_seq_dly: a parametrised valid+data shift register (DEPTH, WIDTH) with synchronous reset. It is used for the out_valid/out_ch path.

Test Plan:
- Defaults; rst then start pulse at edge 10 -> first sample_strobe after edge 18; last_tap after edge 33; out_valid after edge 37; sample_strobe repeats every 16 cycles.
- NUM_CH=3, FILTER_LENGTH=4 -> ch_idx sequence 0,0,0,0,1,1,1,1,2,2,2,2,0; out_ch matches 4 cycles after each last_tap.
- stop at tap_idx=5 of channel 0 -> frame completes to tap 15, no further sample_strobe, out_valid 4 cycles later, done one cycle after, busy drops with done.
- STARTUP_CYCLES=0 -> sample_strobe asserted after edge k+1; stop during WARMUP with STARTUP_CYCLES=7 -> done, no out_valid.
- rst asserted 2 cycles after last_tap -> no out_valid ever appears; all outputs 0 after the rst edge; start while busy -> no restart, tap sequence unchanged.
- FIR_SEQ_HOLD_EN: hold for 3 cycles at tap_idx=7 -> tap_idx stays 7; next last_tap is delayed by 3; an earlier pending out_valid is not delayed.
